tbs_event_packetizer: RTL and testbench

Sits downstream of the TBS/ATBS main FSM and upstream of the UART transmitter. It timestamps each threshold-crossing event (upper, lower or both) as a delta time since the previous record. Records are buffered in a small FIFO and serialised into 2-byte frames on a ready/valid byte stream for the UART TX. Frames carry a sync bit so the host can resynchronise after a flush.

---
 rtl/tbs_event_packetizer.sv | 193 +++++++++++++++++++
 tb/tb_tbs_event_packetizer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbs_event_packetizer.sv
// Timestamps TBS/ATBS threshold-crossing events as delta ticks since the
// previous record, buffers the records in a small FIFO and serialises each
// one into a two-byte frame on a ready/valid byte stream for the UART TX.
// The first byte of every frame has its MSB set so the host can resync.
module tbs_event_packetizer #(
  parameter int TS_PRESCALE = 80,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          event_upper_i,
  input  logic                          event_lower_i,
  output logic [7:0]                    tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          dropped_o
);

  localparam int              PW            = $clog2(TS_PRESCALE);
  localparam int              AW            = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]   PRESC_MAX     = PW'(TS_PRESCALE - 1);
  localparam logic [AW:0]     FIFO_FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0]     DELTA_LAST    = 12'd4094;
  localparam logic [11:0]     TS_TIMEOUT    = 12'd4095;
  localparam logic [1:0]      KIND_UPPER    = 2'b00;
  localparam logic [1:0]      KIND_LOWER    = 2'b01;
  localparam logic [1:0]      KIND_BOTH     = 2'b10;
  localparam logic [1:0]      KIND_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BYTE0, S_BYTE1} ser_state_t;

  // Timestamp side
  logic [PW-1:0] presc;
  logic [11:0]   delta;
  logic          stage_valid;   // one record waiting to be pushed
  logic [13:0]   stage_rec;     // {kind[1:0], ts[11:0]}
  logic [1:0]    event_kind;
  logic          tick;
  logic          any_event;

  // FIFO
  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [13:0]   head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // Serializer
  ser_state_t    state;
  logic [6:0]    frame_lo;      // ts[6:0] of the frame being sent

  assign tick       = (presc == PRESC_MAX);
  assign any_event  = event_upper_i | event_lower_i;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL_LVL);
  assign head       = mem[rd_ptr];
  // The serializer takes a record when idle, or right after the last byte of
  // a frame is accepted so consecutive frames stream without a bubble.
  assign pop        = !fifo_empty &&
                      ((state == S_IDLE) || (state == S_BYTE1 && tx_ready_i));
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push       = stage_valid && (!fifo_full || pop);
  assign fifo_level_o = count;

  function automatic logic [7:0] first_byte(input logic [13:0] rec);
    return {1'b1, rec[13:12], rec[11:7]};
  endfunction

  // Classify the event pulses into the record kind
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    event_kind = KIND_UPPER;
    if (event_upper_i && event_lower_i) event_kind = KIND_BOTH;
    else if (event_lower_i)             event_kind = KIND_LOWER;
  end

  // Prescaler, delta counter and record staging (events beat timeouts)
  always_ff @(posedge clock_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (reset_i) begin
      presc       <= '0;
      delta       <= '0;
      stage_valid <= 1'b0;
      stage_rec   <= '0;
    end else if (!enable_i) begin
      presc       <= '0;
      delta       <= '0;
      stage_valid <= 1'b0;
      stage_rec   <= '0;
    end else if (any_event) begin
      presc       <= '0;
      delta       <= '0;
      stage_valid <= 1'b1;
      stage_rec   <= {event_kind, delta};
    end else if (tick && delta == DELTA_LAST) begin
      presc       <= '0;
      delta       <= '0;
      stage_valid <= 1'b1;
      stage_rec   <= {KIND_TIMEOUT, TS_TIMEOUT};
    end else begin
      presc       <= tick ? '0 : presc + PW'(1);
      delta       <= tick ? delta + 12'd1 : delta;
      stage_valid <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_o <= 1'b0;
    end else if (!enable_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (stage_valid && !push) dropped_o <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clock_i) begin
    // NOTE: the storage array has no reset; the pointers define which entries
    // are valid, and leaving it unreset lets it map onto plain RAM.
    if (push && enable_i) mem[wr_ptr] <= stage_rec;
  end

  // Serializer FSM with registered byte and valid
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      frame_lo   <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
    end else if (!enable_i) begin
      state      <= S_IDLE;
      frame_lo   <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            frame_lo   <= head[6:0];
            tx_data_o  <= first_byte(head);
            tx_valid_o <= 1'b1;
            state      <= S_BYTE0;
          end
        end
        S_BYTE0: begin
          if (tx_ready_i) begin
            tx_data_o <= {1'b0, frame_lo};
            state     <= S_BYTE1;
          end
        end
        S_BYTE1: begin
          if (tx_ready_i) begin
            if (pop) begin
              frame_lo   <= head[6:0];
              tx_data_o  <= first_byte(head);
              tx_valid_o <= 1'b1;
              state      <= S_BYTE0;
            end else begin
              tx_data_o  <= 8'h00;
              tx_valid_o <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: begin
          tx_data_o  <= 8'h00;
          tx_valid_o <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbs_event_packetizer.sv
// Self-checking bench for tbs_event_packetizer. A small prescale keeps the
// 4095-tick timeout reachable in a short run. Expected frames come from a
// model that reasons in cycles since the last record, not from ticks.
module tb_tbs_event_packetizer;

  localparam int P     = 4;           // TS_PRESCALE used for the DUT
  localparam int DEPTH = 8;
  localparam int TO    = 4095 * P;    // cycles from last record to a timeout

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ev_upper;
  logic       ev_lower;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] fifo_level;
  logic       dropped;

  tbs_event_packetizer #(.TS_PRESCALE(P), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .enable_i     (enable),
    .event_upper_i(ev_upper),
    .event_lower_i(ev_lower),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .fifo_level_o (fifo_level),
    .dropped_o    (dropped)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;                        // number of rising edges so far
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  int         stall_err = 0;
  int         last;                   // edge after which delta/prescaler were zero
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // Byte monitor: collects accepted bytes and watches stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data))
          stall_err = stall_err + 1;
        if (tx_valid && tx_ready && enable) rx_q.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready && enable;
        prev_data  = tx_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int kind, input int ts);
    exp_q.push_back(8'(128 + kind * 32 + ts / 128));
    exp_q.push_back(8'(ts % 128));
  endtask

  // Event sampled at edge e: emit any timeouts that fell due first.
  task automatic model_event(input int e, input int kind);
    while (e > last + TO) begin
      push_frame(3, 4095);
      last = last + TO;
    end
    push_frame(kind, (e - last - 1) / P);
    last = e;
  endtask

  task automatic model_sync(input int now);
    while (now >= last + TO) begin
      push_frame(3, 4095);
      last = last + TO;
    end
  endtask

  task automatic drain_compare(input string tag);
    int waited = 0;
    while (rx_q.size() < exp_q.size() && waited < 3000) begin
      step();
      waited++;
    end
    repeat (10) step();
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e;
    int bubbles;
    rst      = 1'b1;
    enable   = 1'b1;
    ev_upper = 1'b0;
    ev_lower = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data",  32'(tx_data),  32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop",  32'(dropped),  32'd0);
    rst  = 1'b0;
    last = cyc;

    // Upper event after three ticks, with latency checks
    repeat (3 * P) step();
    ev_upper = 1'b1;
    e = cyc + 1;
    model_event(e, 0);
    step();
    ev_upper = 1'b0;
    step();
    check("lat_level_n1", 32'(fifo_level), 32'd1);
    check("lat_valid_n1", 32'(tx_valid), 32'd0);
    step();
    check("lat_valid_n2", 32'(tx_valid), 32'd1);
    check("lat_byte0",    32'(tx_data),  32'h80);
    step();
    check("lat_byte1",    32'(tx_data),  32'h03);

    // Simultaneous upper+lower straight away, then a lower event
    ev_upper = 1'b1;
    ev_lower = 1'b1;
    model_event(cyc + 1, 2);
    step();
    ev_upper = 1'b0;
    ev_lower = 1'b0;
    repeat (9) step();
    ev_lower = 1'b1;
    model_event(cyc + 1, 1);
    step();
    ev_lower = 1'b0;
    drain_compare("simul");

    // Timeout frame, then an event landing exactly on the timeout tick
    while (cyc < last + TO + 4) step();
    model_sync(cyc);
    drain_compare("timeout");
    while (cyc < last + TO - 1) step();
    ev_lower = 1'b1;
    model_event(cyc + 1, 1);
    step();
    ev_lower = 1'b0;
    drain_compare("tmo_race");

    // Ten back-to-back events into a stalled stream: one is dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ev_upper = (i % 2 == 0);
      ev_lower = (i % 2 == 1);
      if (i < 9) model_event(cyc + 1, i % 2);
      else       last = cyc + 1;
      step();
    end
    ev_upper = 1'b0;
    ev_lower = 1'b0;
    repeat (4) step();
    check("burst_level", 32'(fifo_level), 32'd8);
    check("burst_drop",  32'(dropped),    32'd1);
    check("burst_valid", 32'(tx_valid),   32'd1);
    check("burst_head",  32'(tx_data),    32'(exp_q[0]));
    tx_ready = 1'b1;
    bubbles  = 0;
    for (int j = 0; j < 18; j++) begin
      if (tx_valid !== 1'b1) bubbles++;
      step();
    end
    check("burst_bubbles", bubbles, 0);
    check("burst_end_valid", 32'(tx_valid), 32'd0);
    check("burst_end_level", 32'(fifo_level), 32'd0);
    check("burst_drop_sticky", 32'(dropped), 32'd1);
    drain_compare("burst");

    // Stall in BYTE1, queue two more records, then abort with enable low
    ev_upper = 1'b1;
    model_event(cyc + 1, 0);
    step();
    ev_upper = 1'b0;
    repeat (3) step();
    tx_ready = 1'b0;
    check("stall_byte1", 32'(tx_data), 32'(exp_q[1]));
    ev_lower = 1'b1;
    step();
    ev_lower = 1'b0;
    step();
    ev_lower = 1'b1;
    step();
    ev_lower = 1'b0;
    repeat (3) step();
    check("stall_hold_valid", 32'(tx_valid), 32'd1);
    check("stall_hold_data",  32'(tx_data),  32'(exp_q[1]));
    check("stall_level",      32'(fifo_level), 32'd2);
    enable = 1'b0;
    step();
    check("abort_valid", 32'(tx_valid),   32'd0);
    check("abort_data",  32'(tx_data),    32'h00);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_drop",  32'(dropped),    32'd0);
    enable   = 1'b1;
    last     = cyc;
    tx_ready = 1'b1;
    void'(exp_q.pop_back());
    drain_compare("abort");

    // Randomised events against random back-pressure
    for (int n = 0; n < 20; n++) begin
      int gap;
      int kind;
      gap = $urandom_range(12, 1500);
      repeat (gap) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      kind     = $urandom_range(0, 2);
      ev_upper = (kind != 1);
      ev_lower = (kind != 0);
      model_event(cyc + 1, kind);
      tx_ready = ($urandom_range(0, 3) != 0);
      step();
      ev_upper = 1'b0;
      ev_lower = 1'b0;
    end
    tx_ready = 1'b1;
    drain_compare("random");
    check("random_drop", 32'(dropped), 32'd0);

    // Asynchronous reset between edges while streaming
    ev_upper = 1'b1;
    repeat (3) step();
    ev_upper = 1'b0;
    repeat (2) step();
    check("pre_rst_valid", 32'(tx_valid),   32'd1);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(tx_valid),   32'd0);
    check("async_data",  32'(tx_data),    32'h00);
    check("async_level", 32'(fifo_level), 32'd0);
    check("async_drop",  32'(dropped),    32'd0);
    repeat (2) step();
    rx_q.delete();
    exp_q.delete();
    rst = 1'b0;
    step();

    check("stall_stability", stall_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
